// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU for the EX stage, result {HI,LO}.
// Optional macro MULDIV_FAST_MUL_EN swaps the multiply loop for a single-cycle multiplier.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   ea,
  input  logic [WIDTH-1:0]   eb,
  input  logic               flush,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t r_state, w_nextState;

  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_opB;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_isDiv;
  logic               r_negQ;
  logic               r_negR;
  logic               r_divZero;
  logic [2*WIDTH-1:0] r_result;

  logic               w_signed;
  logic               w_aNeg;
  logic               w_bNeg;
  logic [WIDTH-1:0]   w_aMag;
  logic [WIDTH-1:0]   w_bMag;
  logic               w_divZero;
  logic               w_launch;
  logic               w_fastMul;
  logic [WIDTH:0]     w_mulSum;
  logic [WIDTH:0]     w_divShift;
  logic               w_divGe;
  logic [WIDTH-1:0]   w_divSub;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [2*WIDTH-1:0] w_fixed;

  assign w_signed  = ~op[0];
  assign w_aNeg    = w_signed & ea[WIDTH-1];
  assign w_bNeg    = w_signed & eb[WIDTH-1];
  assign w_aMag    = w_aNeg ? -ea : ea;
  assign w_bMag    = w_bNeg ? -eb : eb;
  assign w_divZero = op[1] & (eb == '0);
  assign w_launch  = (r_state == IDLE) & start & ~flush;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fastProd;
  assign w_fastMul  = ~op[1];
  assign w_fastProd = {{WIDTH{1'b0}}, w_aMag} * {{WIDTH{1'b0}}, w_bMag};
`else
  assign w_fastMul = 1'b0;
`endif

  // Shift-add keeps {carry,hi,lo} as one right-shifting product; restoring divide
  // shifts left through a WIDTH+1-bit partial remainder so -2^(W-1) magnitudes fit.
  assign w_mulSum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opB} : '0);
  assign w_divShift = {r_hi, r_lo[WIDTH-1]};
  assign w_divGe    = w_divShift >= {1'b0, r_opB};
  assign w_divSub   = w_divShift[WIDTH-1:0] - r_opB;

  assign w_prod  = {r_hi, r_lo};
  assign w_quo   = r_negQ ? -r_lo : r_lo;
  assign w_rem   = r_negR ? -r_hi : r_hi;
  assign w_fixed = r_divZero ? w_prod :
                   r_isDiv   ? {w_rem, w_quo} :
                   r_negQ    ? -w_prod : w_prod;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_nextState;
  end

  // Divide-by-zero parks one cycle in CALC without stepping before its fixup.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:  if (w_launch) w_nextState = w_fastMul ? FIXUP : CALC;
      CALC:  if (r_divZero || r_cnt == CNT_W'(1)) w_nextState = FIXUP;
      FIXUP: w_nextState = DONE;
      DONE:  w_nextState = IDLE;
    endcase
    if (flush && r_state != IDLE) w_nextState = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_opB     <= '0;
      r_cnt     <= '0;
      r_isDiv   <= 1'b0;
      r_negQ    <= 1'b0;
      r_negR    <= 1'b0;
      r_divZero <= 1'b0;
      r_result  <= '0;
    end else begin
      if (w_launch) begin
        r_isDiv   <= op[1];
        r_negQ    <= w_aNeg ^ w_bNeg;
        r_negR    <= w_aNeg;
        r_divZero <= w_divZero;
        r_opB     <= w_bMag;
        if (w_divZero) begin
          r_hi  <= ea;
          r_lo  <= '1;
          r_cnt <= '0;
        end
`ifdef MULDIV_FAST_MUL_EN
        else if (w_fastMul) begin
          r_hi  <= w_fastProd[2*WIDTH-1:WIDTH];
          r_lo  <= w_fastProd[WIDTH-1:0];
          r_cnt <= '0;
        end
`endif
        else begin
          r_hi  <= '0;
          r_lo  <= w_aMag;
          r_cnt <= CNT_W'(WIDTH);
        end
      end else if (r_state == CALC && !r_divZero) begin
        r_cnt <= r_cnt - CNT_W'(1);
        if (r_isDiv) begin
          r_hi <= w_divGe ? w_divSub : w_divShift[WIDTH-1:0];
          r_lo <= {r_lo[WIDTH-2:0], w_divGe};
        end else begin
          r_hi <= w_mulSum[WIDTH:1];
          r_lo <= {w_mulSum[0], r_lo[WIDTH-1:1]};
        end
      end
      if (r_state == FIXUP && !flush) r_result <= w_fixed;
    end
  end

  assign busy   = (r_state == CALC) || (r_state == FIXUP);
  assign done   = (r_state == DONE);
  assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit (honours MULDIV_FAST_MUL_EN for latency).
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] ea;
  logic [31:0] eb;
  logic        flush;
  logic        busy;
  logic        done;
  logic [63:0] result;

  int checks = 0;
  int failures = 0;
  logic [63:0] lastResult = '0;

  typedef struct {
    logic [63:0] res;
    int          lat;
  } exp_t;
  exp_t sb[$];

  muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .ea(ea), .eb(eb),
    .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv, q, r;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    case (o)
      2'b00: return 64'(sa * sbv);
      2'b01: return {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sbv;
        r = sa % sbv;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Cycle 1 is the cycle right after the launch edge.
  function automatic int expLat(input logic [1:0] o, input logic [31:0] b);
    if (o[1] && b == 32'd0) return 3;
`ifdef MULDIV_FAST_MUL_EN
    if (!o[1]) return 2;
`endif
    return 34;
  endfunction

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op = o;
    ea = a;
    eb = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic applyStimulus(input string tag, input logic [1:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic [63:0] expRes, input int restartAt);
    exp_t e;
    int cyc;
    int busyBad;
    e.res = expRes;
    e.lat = expLat(o, b);
    sb.push_back(e);
    launch(o, a, b);
    cyc = 1;
    busyBad = 0;
    while (!done && cyc < 200) begin
      if (!busy) busyBad++;
      if (cyc == restartAt) begin
        start = 1'b1;
        op = ~o;
        ea = ~a;
        eb = b ^ 32'h5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    e = sb.pop_front();
    if (!done) begin
      checkOutput({tag, "_timeout"}, 64'(done), 64'(1));
    end else begin
      checkOutput({tag, "_result"}, result, e.res);
      checkOutput({tag, "_latency"}, 64'(cyc), 64'(e.lat));
      checkOutput({tag, "_busy_during"}, 64'(busyBad), 64'(0));
      checkOutput({tag, "_busy_at_done"}, 64'(busy), 64'(0));
    end
    lastResult = e.res;
    if (cyc == restartAt) begin
      start = 1'b1;
      op = ~o;
      ea = ~a;
      eb = b ^ 32'h5;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput({tag, "_done_pulse"}, 64'(done), 64'(0));
    checkOutput({tag, "_idle_after"}, 64'(busy), 64'(0));
  endtask

  task automatic watchQuiet(input string tag, input int n);
    logic sawDone;
    logic sawBusy;
    sawDone = 1'b0;
    sawBusy = 1'b0;
    for (int c = 0; c < n; c++) begin
      if (done) sawDone = 1'b1;
      if (busy) sawBusy = 1'b1;
      @(posedge clk);
      #1;
    end
    checkOutput({tag, "_no_done"}, 64'(sawDone), 64'(0));
    checkOutput({tag, "_no_busy"}, 64'(sawBusy), 64'(0));
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;

    rst = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op = 2'b00;
    ea = '0;
    eb = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", 64'(busy), 64'(0));
    checkOutput("reset_done", 64'(done), 64'(0));
    checkOutput("reset_result", result, 64'(0));
    @(negedge clk);
    rst = 1'b1;

    applyStimulus("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0);
    applyStimulus("mult_neg3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 0);
    applyStimulus("mult_minxmin", 2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0);
    applyStimulus("div_neg7by2", 2'b10, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    applyStimulus("div_7byneg2", 2'b10, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 0);
    applyStimulus("divu_100by7", 2'b11, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 0);
    applyStimulus("divu_maxby1", 2'b11, 32'hFFFF_FFFF, 32'd1, 64'h0000_0000_FFFF_FFFF, 0);
    applyStimulus("divu_by0", 2'b11, 32'h1234_5678, 32'd0, 64'h1234_5678_FFFF_FFFF, 0);
    applyStimulus("div_neg_by0", 2'b10, 32'hFFFF_FFF9, 32'd0, 64'hFFFF_FFF9_FFFF_FFFF, 0);
    applyStimulus("div_overflow", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 0);
    applyStimulus("div_restart_busy", 2'b10, 32'd1000, 32'hFFFF_FFFD, 64'h0000_0001_FFFF_FEB3, 5);
    applyStimulus("multu_restart_done", 2'b01, 32'd5, 32'd6, 64'd30, expLat(2'b01, 32'd6));

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (i % 2 == 1) rb = rb >> 20;
      if (i == 3) rb = '0;
      applyStimulus("rand", ro, ra, rb, model(ro, ra, rb), 0);
    end

    // Abort mid-operation; DIVU keeps the fast build still in flight at cycle 10.
`ifdef MULDIV_FAST_MUL_EN
    launch(2'b11, 32'd5, 32'd6);
`else
    launch(2'b01, 32'd5, 32'd6);
`endif
    for (int c = 1; c < 10; c++) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flush_busy_next", 64'(busy), 64'(0));
    watchQuiet("flush", 40);
    checkOutput("flush_result_kept", result, lastResult);
    applyStimulus("after_flush", 2'b01, 32'd5, 32'd6, 64'd30, 0);

    launch(2'b10, 32'hFFFF_FFF9, 32'd2);
    for (int c = 1; c < 15; c++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("pre_reset_busy", 64'(busy), 64'(1));
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_reset_busy", 64'(busy), 64'(0));
    checkOutput("async_reset_done", 64'(done), 64'(0));
    checkOutput("async_reset_result", result, 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    lastResult = '0;
    watchQuiet("post_reset", 40);
    checkOutput("post_reset_result", result, lastResult);
    applyStimulus("after_reset", 2'b11, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
